// File: rtl/seq_alu.sv
// Registered ALU for the multicycle CPU datapath with a Start/Done handshake.
// Latency: single-cycle ops Done one edge after accept; mul Done WIDTH+1 edges after accept.
// Backpressure: Start is ignored while Busy=1; Start in the Done cycle is accepted.
// Build option: define SEQ_ALU_MUL_EN for the iterative shift-add multiplier on op 111;
// without it, op 111 takes the single-cycle path and returns 0.
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             Clear,
    input  logic             Start,
    input  logic [2:0]       ALUOp,
    input  logic [WIDTH-1:0] Data1,
    input  logic [WIDTH-1:0] Data2,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ALU_Result,
    output logic             Zero,
    output logic             Carry,
    output logic             Overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam logic [2:0] OP_ZERO = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    state_t           state_q, state_d;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] res_q;
    logic             zero_q, carry_q, ovf_q, done_q;
    logic             accept;

    // single-cycle datapath results, computed from the latched operands
    logic [WIDTH-1:0] sc_res;
    logic             sc_carry, sc_ovf;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH-1:0] diff_w;

`ifdef SEQ_ALU_MUL_EN
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc_q, mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
`endif

    assign accept     = (state_q == S_IDLE) && Start;
    assign Busy       = (state_q != S_IDLE);
    assign Done       = done_q;
    assign ALU_Result = res_q;
    assign Zero       = zero_q;
    assign Carry      = carry_q;
    assign Overflow   = ovf_q;

    // FSM state register; Clear always returns to IDLE, aborting any op
    always_ff @(posedge clk) begin
        if (Clear) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state: EXEC for single-cycle ops, MUL for WIDTH iterations then FIN
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
`ifdef SEQ_ALU_MUL_EN
                    state_d = (ALUOp == OP_MUL) ? S_MUL : S_EXEC;
`else
                    state_d = S_EXEC;
`endif
                end
            end
            S_EXEC: state_d = S_IDLE;
            S_MUL: begin
`ifdef SEQ_ALU_MUL_EN
                if (cnt_q == LAST_ITER) state_d = S_FIN;
`else
                state_d = S_IDLE;
`endif
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand capture on the accepting edge; later input changes are ignored
    always_ff @(posedge clk) begin
        if (Clear) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (accept) begin
            op_q <= ALUOp;
            a_q  <= Data1;
            b_q  <= Data2;
        end
    end

    // Single-cycle op results and flags from the latched operands
    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sum_w    = {1'b0, a_q} + {1'b0, b_q};
        diff_w   = a_q - b_q;
        case (op_q)
            OP_ZERO: sc_res = '0;
            OP_ADD: begin
                sc_res   = sum_w[WIDTH-1:0];
                sc_carry = sum_w[WIDTH];
                sc_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res   = diff_w;
                sc_carry = (a_q < b_q);
                sc_ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND: sc_res = a_q & b_q;
            OP_OR:  sc_res = a_q | b_q;
            OP_XOR: sc_res = a_q ^ b_q;
            OP_SHL: begin
                // amounts that reach WIDTH shift everything out
                if (32'(b_q[SHW-1:0]) >= 32'(WIDTH)) sc_res = '0;
                else                                 sc_res = a_q << b_q[SHW-1:0];
            end
            default: sc_res = '0;   // op 111 without the multiplier
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    // Shift-add multiplier: one multiplier bit consumed per cycle in MUL
    always_ff @(posedge clk) begin
        if (Clear) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (accept) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, Data1};
            mplier_q <= Data2;
            cnt_q    <= '0;
        end else if (state_q == S_MUL) begin
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
        end
    end
`endif

    // Result/flag registers: written only when an op completes, Done pulses once
    always_ff @(posedge clk) begin
        if (Clear) begin
            res_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == S_EXEC) begin
                res_q   <= sc_res;
                zero_q  <= (sc_res == '0);
                carry_q <= sc_carry;
                ovf_q   <= sc_ovf;
                done_q  <= 1'b1;
            end
`ifdef SEQ_ALU_MUL_EN
            if (state_q == S_FIN) begin
                res_q   <= acc_q[WIDTH-1:0];
                zero_q  <= (acc_q[WIDTH-1:0] == '0);
                carry_q <= 1'b0;
                ovf_q   <= |acc_q[2*WIDTH-1:WIDTH];
                done_q  <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases plus random ops against an arithmetic model.
module tb_seq_alu;

    localparam int W  = 8;
    localparam int SH = 3;
`ifdef SEQ_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         Clear, Start;
    logic [2:0]   ALUOp;
    logic [W-1:0] Data1, Data2;
    logic         Busy, Done, Zero, Carry, Overflow;
    logic [W-1:0] ALU_Result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W), .SHW(SH)) dut (
        .clk(clk), .Clear(Clear), .Start(Start), .ALUOp(ALUOp),
        .Data1(Data1), .Data2(Data2), .Busy(Busy), .Done(Done),
        .ALU_Result(ALU_Result), .Zero(Zero), .Carry(Carry), .Overflow(Overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the op definitions
    function automatic void model(input int op, input int a, input int b,
                                  output int res, output int c, output int v, output int lat);
        int m, half, sa, sb, t, amt;
        m    = 1 << W;
        half = 1 << (W - 1);
        sa   = (a >= half) ? a - m : a;
        sb   = (b >= half) ? b - m : b;
        res = 0; c = 0; v = 0; lat = 1;
        case (op)
            1: begin
                t = a + b; res = t % m; c = (t >= m) ? 1 : 0;
                t = sa + sb; v = (t >= half || t < -half) ? 1 : 0;
            end
            2: begin
                res = (a - b + m) % m; c = (a < b) ? 1 : 0;
                t = sa - sb; v = (t >= half || t < -half) ? 1 : 0;
            end
            3: res = a & b;
            4: res = a | b;
            5: res = a ^ b;
            6: begin
                amt = b % (1 << SH);
                res = (amt >= W) ? 0 : (a << amt) % m;
            end
            7: if (MUL_EN) begin
                t = a * b; res = t % m; v = (t >= m) ? 1 : 0; lat = W + 1;
            end
            default: res = 0;
        endcase
    endfunction

    // Issue one op at the current negedge, scramble inputs after acceptance, wait for Done.
    // With hold=0 the task returns in the Done cycle so the next op issues back-to-back.
    task automatic run_op(input string name, input int op, input int a, input int b, input bit hold);
        int er, ec, ev, el, lat, busy_cnt;
        model(op, a, b, er, ec, ev, el);
        ALUOp = op[2:0]; Data1 = a[W-1:0]; Data2 = b[W-1:0]; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        ALUOp = 3'($urandom); Data1 = W'($urandom); Data2 = W'($urandom);
        chk({name, ":busy_after_accept"}, 32'(Busy), 32'(1));
        lat = 0; busy_cnt = 0;
        while (Done !== 1'b1 && lat < 40) begin
            if (Busy === 1'b1) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        chk({name, ":latency"},    32'(lat),        32'(el));
        chk({name, ":busy_cycles"}, 32'(busy_cnt),  32'(el));
        chk({name, ":result"},     32'(ALU_Result), 32'(er));
        chk({name, ":zero"},       32'(Zero),       32'(er == 0));
        chk({name, ":carry"},      32'(Carry),      32'(ec));
        chk({name, ":overflow"},   32'(Overflow),   32'(ev));
        chk({name, ":idle_at_done"}, 32'(Busy),     32'(0));
        if (hold) begin
            @(negedge clk);
            chk({name, ":done_pulse"},  32'(Done),       32'(0));
            chk({name, ":result_held"}, 32'(ALU_Result), 32'(er));
        end
    endtask

    initial begin
        int dones, hold_bit;
        Clear = 1'b1; Start = 1'b0; ALUOp = '0; Data1 = '0; Data2 = '0;
        @(negedge clk); @(negedge clk);
        chk("rst:busy",   32'(Busy),       32'(0));
        chk("rst:done",   32'(Done),       32'(0));
        chk("rst:result", 32'(ALU_Result), 32'(0));
        chk("rst:zero",   32'(Zero),       32'(0));
        chk("rst:carry",  32'(Carry),      32'(0));
        chk("rst:ovf",    32'(Overflow),   32'(0));
        Clear = 1'b0;
        @(negedge clk);

        // Directed cases
        run_op("add200_100", 1, 200, 100, 1'b1);
        run_op("sub5_7",     2, 5, 7, 1'b1);
        run_op("sub80_01",   2, 8'h80, 8'h01, 1'b1);
        run_op("add7f_01",   1, 8'h7F, 8'h01, 1'b1);
        run_op("mul13_11",   7, 13, 11, 1'b1);
        run_op("mul20_20",   7, 20, 20, 1'b1);
        run_op("shl81_1",    6, 8'h81, 1, 1'b1);
        run_op("shl81_09",   6, 8'h81, 8'h09, 1'b1);
        run_op("xorAA",      5, 8'hAA, 8'hAA, 1'b1);
        run_op("zero_op",    0, 8'h55, 8'h33, 1'b1);
        run_op("and",        3, 8'hF0, 8'h3C, 1'b1);
        run_op("or",         4, 8'hF0, 8'h0C, 1'b1);
        // Back-to-back: second and third ops issue in the Done cycle
        run_op("b2b_a",      1, 1, 2, 1'b0);
        run_op("b2b_b",      7, 15, 17, 1'b0);
        run_op("b2b_c",      2, 3, 9, 1'b1);

        // Start during a multiply is dropped, not queued
        if (MUL_EN) begin
            ALUOp = 3'b111; Data1 = 8'd13; Data2 = 8'd11; Start = 1'b1;
            @(negedge clk); Start = 1'b0;
            @(negedge clk); @(negedge clk);
            ALUOp = 3'b001; Data1 = 8'd1; Data2 = 8'd1; Start = 1'b1;
            @(negedge clk); Start = 1'b0;
            dones = 0;
            for (int i = 0; i < 14; i++) begin
                if (Done === 1'b1) begin
                    dones++;
                    chk("busy_start:result", 32'(ALU_Result), 32'(8'h8F));
                end
                @(negedge clk);
            end
            chk("busy_start:done_count", 32'(dones), 32'(1));
        end

        // Clear mid-multiply: aborts with no Done, all outputs zero
        ALUOp = 3'b111; Data1 = 8'd3; Data2 = 8'd3; Start = 1'b1;
        @(negedge clk); Start = 1'b0;
        @(negedge clk); @(negedge clk);
        ALUOp = 3'b001; Data1 = 8'd1; Data2 = 8'd1; Start = 1'b1;
        @(negedge clk); Start = 1'b0;
        @(negedge clk);
        chk("clr:busy_before", 32'(Busy), 32'(MUL_EN));
        Clear = 1'b1;
        @(negedge clk); Clear = 1'b0;
        chk("clr:busy",   32'(Busy),       32'(0));
        chk("clr:done",   32'(Done),       32'(0));
        chk("clr:result", 32'(ALU_Result), 32'(0));
        chk("clr:zero",   32'(Zero),       32'(0));
        chk("clr:carry",  32'(Carry),      32'(0));
        chk("clr:ovf",    32'(Overflow),   32'(0));
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (Done === 1'b1) dones++;
            @(negedge clk);
        end
        chk("clr:no_done", 32'(dones), 32'(0));
        run_op("post_clr_add", 1, 1, 1, 1'b1);

        // Random ops against the model
        for (int n = 0; n < 150; n++) begin
            hold_bit = int'($urandom_range(1));
            run_op("rand", int'($urandom_range(7)), int'($urandom_range(255)),
                   int'($urandom_range(255)), hold_bit[0]);
        end
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
